// File: rtl/v810_biu16.sv
// ---------------------------------------------------------------------------
// v810_biu16 -- data-side bus interface unit for the V810 core.
//
// Takes one 32-bit data request from the core and turns it into one or two
// 16-bit external bus cycles. The low half goes first, then the high half.
// A half whose byte enables are all inactive gets no bus cycle. Each bus
// cycle inserts NWAIT fixed wait states. After those, READYn is sampled
// until it goes low. C_READY pulses for one CE-cycle when the access is done.
//
// Parameters:
//   NWAIT    fixed wait states per bus cycle before READYn is sampled
//
// Ports:
//   clk      clock, all state on posedge
//   res      synchronous active-high reset
//   ce       clock enable, state advances only when high
//   c_a      core byte address, bits [1:0] ignored
//   c_do     core write data
//   c_ben    core byte enables, active-low, one bit per byte lane
//   c_mrqn   core memory request, active-low
//   c_rw     core direction, 1 = read
//   c_di     read data returned to the core
//   c_ready  access complete, one CE-cycle pulse
//   a        bus address, a[0] always 0
//   d_o      bus write data
//   d_i      bus read data
//   ben      bus byte enables, active-low
//   mrqn     bus request, active-low
//   rw       bus direction, 1 = read
//   readyn   bus cycle done, active-low
// ---------------------------------------------------------------------------
module v810_biu16 #(
    parameter int NWAIT = 0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ce,
    input  logic [31:0] c_a,
    input  logic [31:0] c_do,
    input  logic [3:0]  c_ben,
    input  logic        c_mrqn,
    input  logic        c_rw,
    output logic [31:0] c_di,
    output logic        c_ready,
    output logic [31:0] a,
    output logic [15:0] d_o,
    input  logic [15:0] d_i,
    output logic [1:0]  ben,
    output logic        mrqn,
    output logic        rw,
    input  logic        readyn
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(NWAIT);

    state_t      state, state_nx;
    logic [29:0] addr_q, addr_nx;
    logic [15:0] data_hi_q, data_hi_nx;
    logic [1:0]  ben_hi_q, ben_hi_nx;
    logic [7:0]  wcnt, wcnt_nx;
    logic [31:0] c_di_nx, a_nx;
    logic [15:0] d_o_nx;
    logic [1:0]  ben_nx;
    logic        c_ready_nx, mrqn_nx, rw_nx;

    // Word alignment is implied; the byte offset is intentionally dropped.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^c_a[1:0];

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_hi_q <= '0;
            ben_hi_q  <= 2'b11;
            wcnt      <= '0;
            c_di      <= '0;
            c_ready   <= 1'b0;
            a         <= '0;
            d_o       <= '0;
            ben       <= 2'b11;
            mrqn      <= 1'b1;
            rw        <= 1'b1;
        end else begin
            state     <= state_nx;
            addr_q    <= addr_nx;
            data_hi_q <= data_hi_nx;
            ben_hi_q  <= ben_hi_nx;
            wcnt      <= wcnt_nx;
            c_di      <= c_di_nx;
            c_ready   <= c_ready_nx;
            a         <= a_nx;
            d_o       <= d_o_nx;
            ben       <= ben_nx;
            mrqn      <= mrqn_nx;
            rw        <= rw_nx;
        end
    end

    // Next-state logic. Bus outputs are computed here and registered on the
    // edge that enters LO or HI. They are therefore stable for the whole bus
    // cycle. With ce low every register keeps its value.
    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        data_hi_nx = data_hi_q;
        ben_hi_nx  = ben_hi_q;
        wcnt_nx    = wcnt;
        c_di_nx    = c_di;
        c_ready_nx = c_ready;
        a_nx       = a;
        d_o_nx     = d_o;
        ben_nx     = ben;
        mrqn_nx    = mrqn;
        rw_nx      = rw;
        if (ce) begin
            case (state)
                IDLE: begin
                    if (!c_mrqn) begin
                        addr_nx    = c_a[31:2];
                        data_hi_nx = c_do[31:16];
                        ben_hi_nx  = c_ben[3:2];
                        rw_nx      = c_rw;
                        c_di_nx    = '0;
                        wcnt_nx    = '0;
                        if (!(&c_ben[1:0])) begin
                            state_nx = LO;
                            mrqn_nx  = 1'b0;
                            a_nx     = {c_a[31:2], 2'b00};
                            ben_nx   = c_ben[1:0];
                            d_o_nx   = c_do[15:0];
                        end else if (!(&c_ben[3:2])) begin
                            state_nx = HI;
                            mrqn_nx  = 1'b0;
                            a_nx     = {c_a[31:2], 2'b10};
                            ben_nx   = c_ben[3:2];
                            d_o_nx   = c_do[31:16];
                        end else begin
                            // No byte enabled at all: finish without a bus cycle.
                            state_nx   = DONE;
                            c_ready_nx = 1'b1;
                        end
                    end
                end
                LO, HI: begin
                    if (wcnt != WAIT_LAST) begin
                        wcnt_nx = wcnt + 8'd1;
                    end else if (!readyn) begin
                        if (rw) begin
                            if (state == LO) c_di_nx[15:0]  = d_i;
                            else             c_di_nx[31:16] = d_i;
                        end
                        if (state == LO && !(&ben_hi_q)) begin
                            // Go straight into the high half. mrqn stays low.
                            state_nx = HI;
                            wcnt_nx  = '0;
                            a_nx     = {addr_q, 2'b10};
                            ben_nx   = ben_hi_q;
                            d_o_nx   = data_hi_q;
                        end else begin
                            state_nx   = DONE;
                            mrqn_nx    = 1'b1;
                            c_ready_nx = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nx   = IDLE;
                    c_ready_nx = 1'b0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v810_biu16.sv
// ---------------------------------------------------------------------------
// tb_v810_biu16 -- self-checking bench for v810_biu16.
// Two instances are used: one with NWAIT=0 and one with NWAIT=2. The core
// request is steered to one of them. A small bus responder answers with
// fixed data for the low and high halves.
// ---------------------------------------------------------------------------
module tb_v810_biu16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        res, ce, c_mrqn, c_rw, readyn;
    logic [31:0] c_a, c_do;
    logic [3:0]  c_ben;
    logic [15:0] d_i, bus_lo, bus_hi;
    int          sel;

    logic        c_mrqn0, c_mrqn1;
    logic [31:0] c_di0, c_di1, a0, a1;
    logic        c_ready0, c_ready1, mrqn0, mrqn1, rw0, rw1;
    logic [15:0] d_o0, d_o1;
    logic [1:0]  ben0, ben1;

    logic [31:0] obs_c_di, obs_a;
    logic        obs_c_ready, obs_mrqn, obs_rw;
    logic [15:0] obs_d_o;
    logic [1:0]  obs_ben;

    int tests_run = 0;
    int tests_failed = 0;

    assign c_mrqn0 = (sel == 0) ? c_mrqn : 1'b1;
    assign c_mrqn1 = (sel == 1) ? c_mrqn : 1'b1;

    v810_biu16 #(.NWAIT(0)) dut0 (
        .clk(clk), .res(res), .ce(ce), .c_a(c_a), .c_do(c_do), .c_ben(c_ben),
        .c_mrqn(c_mrqn0), .c_rw(c_rw), .c_di(c_di0), .c_ready(c_ready0),
        .a(a0), .d_o(d_o0), .d_i(d_i), .ben(ben0), .mrqn(mrqn0), .rw(rw0),
        .readyn(readyn)
    );

    v810_biu16 #(.NWAIT(2)) dut1 (
        .clk(clk), .res(res), .ce(ce), .c_a(c_a), .c_do(c_do), .c_ben(c_ben),
        .c_mrqn(c_mrqn1), .c_rw(c_rw), .c_di(c_di1), .c_ready(c_ready1),
        .a(a1), .d_o(d_o1), .d_i(d_i), .ben(ben1), .mrqn(mrqn1), .rw(rw1),
        .readyn(readyn)
    );

    // Observe the selected instance.
    always_comb begin
        obs_c_di    = (sel == 1) ? c_di1    : c_di0;
        obs_c_ready = (sel == 1) ? c_ready1 : c_ready0;
        obs_a       = (sel == 1) ? a1       : a0;
        obs_d_o     = (sel == 1) ? d_o1     : d_o0;
        obs_ben     = (sel == 1) ? ben1     : ben0;
        obs_mrqn    = (sel == 1) ? mrqn1    : mrqn0;
        obs_rw      = (sel == 1) ? rw1      : rw0;
    end

    // Bus memory: the high half answers at a[1]=1, the low half otherwise.
    always_comb d_i = obs_a[1] ? bus_hi : bus_lo;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic        rw;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] exp_cdi;
        int          exp_lat;
        int          exp_nbus;
        logic [31:0] exp_a1;
        logic [31:0] exp_a2;
        logic [1:0]  exp_ben1;
        logic [15:0] exp_do1;
        logic [15:0] exp_do2;
    } vec_t;

    typedef struct {
        int          lat;
        int          nbus;
        int          achg;
        int          rdyclk;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] cdi;
        logic [31:0] cdi_after;
        logic [1:0]  ben1;
        logic [15:0] do1;
        logic [15:0] do2;
        logic        rw1;
        logic        timeout;
    } res_t;

    vec_t vecs[8];

    function automatic vec_t mk(string n, logic [31:0] ad, logic [31:0] wd,
                                logic [3:0] be, logic r, logic [15:0] lo,
                                logic [15:0] hi, logic [31:0] cdi, int lat,
                                int nbus, logic [31:0] ea1, logic [31:0] ea2,
                                logic [1:0] eb1, logic [15:0] ed1,
                                logic [15:0] ed2);
        vec_t v;
        v.name = n; v.addr = ad; v.wdata = wd; v.ben = be; v.rw = r;
        v.lo = lo; v.hi = hi; v.exp_cdi = cdi; v.exp_lat = lat;
        v.exp_nbus = nbus; v.exp_a1 = ea1; v.exp_a2 = ea2; v.exp_ben1 = eb1;
        v.exp_do1 = ed1; v.exp_do2 = ed2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request to the selected instance and follow it to C_READY.
    // Called at a sample point (#1 after posedge) while the DUT is idle.
    // holds = number of cycles READYn is driven high while the low half is
    // on the bus. half_rate toggles CE every clock.
    task automatic applyStimulus(input int inst, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic r, input logic [15:0] lo,
                                 input logic [15:0] hi, input int holds,
                                 input bit half_rate, output res_t rs);
        int          holds_left = holds;
        logic [31:0] prev_a = '0;
        rs = '{default: '0};
        rs.lat = -1;
        sel = inst;
        c_a = addr; c_do = wdata; c_ben = be; c_rw = r;
        bus_lo = lo; bus_hi = hi;
        readyn = 1'b0;
        ce = 1'b1;
        c_mrqn = 1'b0;
        @(posedge clk); #1;
        c_mrqn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (!obs_mrqn) begin
                if (rs.nbus == 0) begin
                    rs.a1 = obs_a; rs.ben1 = obs_ben; rs.do1 = obs_d_o;
                    rs.rw1 = obs_rw;
                end else if (obs_a != prev_a) begin
                    rs.achg++;
                end
                prev_a = obs_a;
                rs.a2 = obs_a; rs.do2 = obs_d_o;
                rs.nbus++;
            end
            if (obs_c_ready) begin
                rs.lat = k;
                break;
            end
            if (holds_left > 0 && !obs_mrqn && !obs_a[1]) begin
                readyn = 1'b1;
                holds_left--;
            end else begin
                readyn = 1'b0;
            end
            ce = half_rate ? ~ce : 1'b1;
            @(posedge clk); #1;
        end
        rs.timeout = (rs.lat < 0);
        rs.cdi = obs_c_di;
        rs.rdyclk = rs.timeout ? 0 : 1;
        readyn = 1'b0;
        if (!rs.timeout) begin
            for (int j = 0; j < 4; j++) begin
                ce = half_rate ? ~ce : 1'b1;
                @(posedge clk); #1;
                if (obs_c_ready) rs.rdyclk++;
                else break;
            end
        end
        rs.cdi_after = obs_c_di;
        ce = 1'b1;
    endtask

    initial begin
        res_t rs;
        int   stray;

        vecs[0] = mk("word_rd",  32'h100, 32'h0,        4'b0000, 1'b1, 16'h1234, 16'hABCD, 32'hABCD1234, 3, 2, 32'h100, 32'h102, 2'b00, 16'h0,    16'h0);
        vecs[1] = mk("half_wr",  32'h200, 32'hABCD1234, 4'b0011, 1'b0, 16'h0,    16'h0,    32'h0,        2, 1, 32'h202, 32'h202, 2'b00, 16'hABCD, 16'hABCD);
        vecs[2] = mk("byte_rd",  32'h300, 32'h0,        4'b1110, 1'b1, 16'h55AA, 16'h1111, 32'h000055AA, 2, 1, 32'h300, 32'h300, 2'b10, 16'h0,    16'h0);
        vecs[3] = mk("no_bytes", 32'h400, 32'h0,        4'b1111, 1'b1, 16'h0001, 16'h0002, 32'h0,        1, 0, 32'h0,   32'h0,   2'b11, 16'h0,    16'h0);
        vecs[4] = mk("word_wr",  32'h404, 32'h11223344, 4'b0000, 1'b0, 16'h0,    16'h0,    32'h0,        3, 2, 32'h404, 32'h406, 2'b00, 16'h3344, 16'h1122);
        vecs[5] = mk("split_be", 32'h500, 32'h0,        4'b0101, 1'b1, 16'hBEEF, 16'hCAFE, 32'hCAFEBEEF, 3, 2, 32'h500, 32'h502, 2'b01, 16'h0,    16'h0);
        vecs[6] = mk("lo_half",  32'h600, 32'h0,        4'b1100, 1'b1, 16'h7777, 16'h9999, 32'h00007777, 2, 1, 32'h600, 32'h600, 2'b00, 16'h0,    16'h0);
        vecs[7] = mk("addr_lsb", 32'h703, 32'h0,        4'b0000, 1'b1, 16'h0102, 16'h0304, 32'h03040102, 3, 2, 32'h700, 32'h702, 2'b00, 16'h0,    16'h0);

        sel = 0; res = 1'b1; ce = 1'b1; c_mrqn = 1'b1; c_rw = 1'b1;
        c_a = '0; c_do = '0; c_ben = 4'hF; readyn = 1'b0;
        bus_lo = '0; bus_hi = '0;
        repeat (2) @(posedge clk);
        #1; res = 1'b0;

        // Reset state of both instances.
        checkOutput("rst_mrqn0",  {31'd0, mrqn0}, 32'd1);
        checkOutput("rst_rw0",    {31'd0, rw0}, 32'd1);
        checkOutput("rst_ben0",   {30'd0, ben0}, 32'd3);
        checkOutput("rst_a0",     a0, 32'h0);
        checkOutput("rst_do0",    {16'd0, d_o0}, 32'h0);
        checkOutput("rst_cdi0",   c_di0, 32'h0);
        checkOutput("rst_rdy0",   {31'd0, c_ready0}, 32'd0);
        checkOutput("rst_mrqn1",  {31'd0, mrqn1}, 32'd1);
        checkOutput("rst_rdy1",   {31'd0, c_ready1}, 32'd0);

        // Directed vectors on the zero-wait instance.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, vecs[i].addr, vecs[i].wdata, vecs[i].ben,
                          vecs[i].rw, vecs[i].lo, vecs[i].hi, 0, 1'b0, rs);
            checkOutput({vecs[i].name, "_timeout"}, {31'd0, rs.timeout}, 32'd0);
            checkOutput({vecs[i].name, "_cdi"},   rs.cdi, vecs[i].exp_cdi);
            checkOutput({vecs[i].name, "_lat"},   32'(rs.lat), 32'(vecs[i].exp_lat));
            checkOutput({vecs[i].name, "_nbus"},  32'(rs.nbus), 32'(vecs[i].exp_nbus));
            checkOutput({vecs[i].name, "_rdy1"},  32'(rs.rdyclk), 32'd1);
            checkOutput({vecs[i].name, "_hold"},  rs.cdi_after, vecs[i].exp_cdi);
            if (vecs[i].exp_nbus > 0) begin
                checkOutput({vecs[i].name, "_a1"},   rs.a1, vecs[i].exp_a1);
                checkOutput({vecs[i].name, "_a2"},   rs.a2, vecs[i].exp_a2);
                checkOutput({vecs[i].name, "_ben1"}, {30'd0, rs.ben1}, {30'd0, vecs[i].exp_ben1});
                checkOutput({vecs[i].name, "_do1"},  {16'd0, rs.do1}, {16'd0, vecs[i].exp_do1});
                checkOutput({vecs[i].name, "_do2"},  {16'd0, rs.do2}, {16'd0, vecs[i].exp_do2});
                checkOutput({vecs[i].name, "_rw"},   {31'd0, rs.rw1}, {31'd0, vecs[i].rw});
            end
        end

        // READYn high for three sampled edges in LO, NWAIT=0.
        applyStimulus(0, 32'h900, 32'h0, 4'b0000, 1'b1, 16'h5151, 16'h6262, 3, 1'b0, rs);
        checkOutput("wait0_word_lat",  32'(rs.lat), 32'd6);
        checkOutput("wait0_word_nbus", 32'(rs.nbus), 32'd5);
        checkOutput("wait0_word_achg", 32'(rs.achg), 32'd1);
        checkOutput("wait0_word_cdi",  rs.cdi, 32'h62625151);
        applyStimulus(0, 32'h800, 32'h0, 4'b1100, 1'b1, 16'h4242, 16'h0, 3, 1'b0, rs);
        checkOutput("wait0_half_lat",  32'(rs.lat), 32'd5);
        checkOutput("wait0_half_nbus", 32'(rs.nbus), 32'd4);
        checkOutput("wait0_half_achg", 32'(rs.achg), 32'd0);
        checkOutput("wait0_half_cdi",  rs.cdi, 32'h00004242);

        // NWAIT=2: the same half access takes two more cycles.
        applyStimulus(1, 32'h800, 32'h0, 4'b1100, 1'b1, 16'h4343, 16'h0, 5, 1'b0, rs);
        checkOutput("wait2_half_lat",  32'(rs.lat), 32'd7);
        checkOutput("wait2_half_nbus", 32'(rs.nbus), 32'd6);
        checkOutput("wait2_half_achg", 32'(rs.achg), 32'd0);
        checkOutput("wait2_half_cdi",  rs.cdi, 32'h00004343);
        applyStimulus(1, 32'h880, 32'h0, 4'b0000, 1'b1, 16'h1111, 16'h2222, 0, 1'b0, rs);
        checkOutput("wait2_word_lat",  32'(rs.lat), 32'd7);
        checkOutput("wait2_word_cdi",  rs.cdi, 32'h22221111);
        checkOutput("wait2_word_achg", 32'(rs.achg), 32'd1);

        // Reset while the high half is on the bus.
        sel = 0; c_a = 32'hA00; c_do = '0; c_ben = 4'b0000; c_rw = 1'b1;
        bus_lo = 16'h0001; bus_hi = 16'h0002; readyn = 1'b0; ce = 1'b1;
        c_mrqn = 1'b0;
        @(posedge clk); #1;
        c_mrqn = 1'b1;
        checkOutput("rstmid_a_lo", a0, 32'hA00);
        @(posedge clk); #1;
        checkOutput("rstmid_a_hi", a0, 32'hA02);
        checkOutput("rstmid_mrqn_hi", {31'd0, mrqn0}, 32'd0);
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        checkOutput("rstmid_mrqn", {31'd0, mrqn0}, 32'd1);
        checkOutput("rstmid_rdy",  {31'd0, c_ready0}, 32'd0);
        checkOutput("rstmid_a",    a0, 32'h0);
        checkOutput("rstmid_ben",  {30'd0, ben0}, 32'd3);
        checkOutput("rstmid_cdi",  c_di0, 32'h0);
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (c_ready0 || !mrqn0) stray++;
        end
        checkOutput("rstmid_quiet", 32'(stray), 32'd0);
        applyStimulus(0, 32'hA10, 32'h0, 4'b0000, 1'b1, 16'h3333, 16'h4444, 0, 1'b0, rs);
        checkOutput("after_rst_lat", 32'(rs.lat), 32'd3);
        checkOutput("after_rst_cdi", rs.cdi, 32'h44443333);

        // Word read with CE toggling every clock.
        applyStimulus(0, 32'h100, 32'h0, 4'b0000, 1'b1, 16'h1234, 16'hABCD, 0, 1'b1, rs);
        checkOutput("half_rate_lat",  32'(rs.lat), 32'd5);
        checkOutput("half_rate_nbus", 32'(rs.nbus), 32'd4);
        checkOutput("half_rate_rdy",  32'(rs.rdyclk), 32'd2);
        checkOutput("half_rate_cdi",  rs.cdi, 32'hABCD1234);
        checkOutput("half_rate_a1",   rs.a1, 32'h100);
        checkOutput("half_rate_a2",   rs.a2, 32'h102);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
